// File: rtl/keypad_pkg.sv
// Shared keypad definitions: 5-bit key codes, emulator state encoding, key position.
// Used by both the keypad scanner and the keypad emulator.
package keypad_pkg;

    localparam logic [4:0] KEY_1    = 5'b00001;
    localparam logic [4:0] KEY_2    = 5'b00010;
    localparam logic [4:0] KEY_3    = 5'b00011;
    localparam logic [4:0] KEY_4    = 5'b00100;
    localparam logic [4:0] KEY_5    = 5'b00101;
    localparam logic [4:0] KEY_6    = 5'b00110;
    localparam logic [4:0] KEY_7    = 5'b00111;
    localparam logic [4:0] KEY_8    = 5'b01000;
    localparam logic [4:0] KEY_9    = 5'b01001;
    localparam logic [4:0] KEY_A    = 5'b01010;
    localparam logic [4:0] KEY_B    = 5'b01011;
    localparam logic [4:0] KEY_C    = 5'b01100;
    localparam logic [4:0] KEY_D    = 5'b01101;
    localparam logic [4:0] KEY_STAR = 5'b10000;
    localparam logic [4:0] KEY_0    = 5'b10001;
    localparam logic [4:0] KEY_HASH = 5'b10010;
    localparam logic [4:0] KEY_NONE = 5'b11111;

    localparam int KP_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } kp_state_e;

    // Index 0 is the top row / left column.
    typedef struct packed {
        logic [1:0] row_idx;
        logic [1:0] col_idx;
    } kp_pos_t;

endpackage

// File: rtl/keypad_code_to_pos.sv
// Combinational key-code decoder: 5-bit key code -> row/column index and a valid flag.
module keypad_code_to_pos
    import keypad_pkg::*;
(
    input  logic [4:0] key_code,
    output logic [1:0] row_idx,
    output logic [1:0] col_idx,
    output logic       valid
);

    always_comb begin
        row_idx = 2'd0;
        col_idx = 2'd0;
        valid   = 1'b1;
        case (key_code)
            KEY_1:    begin row_idx = 2'd0; col_idx = 2'd0; end
            KEY_2:    begin row_idx = 2'd0; col_idx = 2'd1; end
            KEY_3:    begin row_idx = 2'd0; col_idx = 2'd2; end
            KEY_A:    begin row_idx = 2'd0; col_idx = 2'd3; end
            KEY_4:    begin row_idx = 2'd1; col_idx = 2'd0; end
            KEY_5:    begin row_idx = 2'd1; col_idx = 2'd1; end
            KEY_6:    begin row_idx = 2'd1; col_idx = 2'd2; end
            KEY_B:    begin row_idx = 2'd1; col_idx = 2'd3; end
            KEY_7:    begin row_idx = 2'd2; col_idx = 2'd0; end
            KEY_8:    begin row_idx = 2'd2; col_idx = 2'd1; end
            KEY_9:    begin row_idx = 2'd2; col_idx = 2'd2; end
            KEY_C:    begin row_idx = 2'd2; col_idx = 2'd3; end
            KEY_STAR: begin row_idx = 2'd3; col_idx = 2'd0; end
            KEY_0:    begin row_idx = 2'd3; col_idx = 2'd1; end
            KEY_HASH: begin row_idx = 2'd3; col_idx = 2'd2; end
            KEY_D:    begin row_idx = 2'd3; col_idx = 2'd3; end
            default:  valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/keypad_emulator.sv
// Keypad emulator: closes one key contact of a 4x4 matrix for HOLD_CYCLES, then forces
// GAP_CYCLES of release. Optional contact bounce model under KEYPAD_EMU_BOUNCE_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; contact open
// HOLD    | contact closed (bounces at first if KEYPAD_EMU_BOUNCE_EN)
// GAP     | contact forced open; done pulses on the last GAP cycle
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] key_code,
    input  logic [3:0] row,
    output logic [3:0] column,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [KP_CNT_W-1:0] HOLD_LOAD = KP_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [KP_CNT_W-1:0] GAP_LOAD  = KP_CNT_W'(GAP_CYCLES - 1);

    kp_state_e             state_q, state_d;
    logic [KP_CNT_W-1:0]   cnt_q, cnt_d;
    kp_pos_t               pos_q, pos_d, code_pos;
    logic                  code_valid;
    logic                  err_q, err_d;
    logic                  accept;
    logic                  contact;

    keypad_code_to_pos u_code_to_pos (
        .key_code (key_code),
        .row_idx  (code_pos.row_idx),
        .col_idx  (code_pos.col_idx),
        .valid    (code_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pos_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
        end
    end

    // The done cycle doubles as an accept window so presses can run back to back.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        err_d   = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: accept = 1'b1;
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (accept && start) begin
            if (code_valid) begin
                state_d = ST_HOLD;
                cnt_d   = HOLD_LOAD;
                pos_d   = code_pos;
            end else begin
                err_d = 1'b1;
            end
        end
    end

`ifdef KEYPAD_EMU_BOUNCE_EN
    logic [KP_CNT_W-1:0] hold_elapsed;
    logic                bounce_open;

    // Odd cycles among the first four of HOLD are open; shorter holds just truncate.
    assign hold_elapsed = HOLD_LOAD - cnt_q;
    assign bounce_open  = (hold_elapsed < KP_CNT_W'(4)) && hold_elapsed[0];
    assign contact      = (state_q == ST_HOLD) && !bounce_open;
`else
    assign contact = (state_q == ST_HOLD);
`endif

    always_comb begin
        column = 4'b1111;
        if (contact && !row[2'd3 - pos_q.row_idx])
            column[2'd3 - pos_q.col_idx] = 1'b0;
    end

    assign busy = (state_q == ST_HOLD) || (state_q == ST_GAP);
    assign err  = err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: stimulus queues expected done/err events,
// a negedge monitor pops and checks them; column/busy are checked per cycle.
module tb_keypad_emulator;
    import keypad_pkg::*;

    localparam int HOLD = 16;
    localparam int GAP  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] key_code = 5'b0;
    logic [3:0] tb_row = 4'b1111;
    logic [3:0] scan_row = 4'b0111;
    logic       scan_en = 1'b0;
    logic [3:0] row;
    logic [3:0] column;
    logic       busy, done, err;
    logic [4:0] decoded = 5'b11111;

    assign row = scan_en ? scan_row : tb_row;

    keypad_emulator #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_code (key_code),
        .row      (row),
        .column   (column),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit is_err;
        int at;
    } evt_t;
    evt_t exp_q[$];
    evt_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit code_ok(input logic [4:0] c);
        case (c)
            5'b00001, 5'b00010, 5'b00011, 5'b01010,
            5'b00100, 5'b00101, 5'b00110, 5'b01011,
            5'b00111, 5'b01000, 5'b01001, 5'b01100,
            5'b10000, 5'b10001, 5'b10010, 5'b01101: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit contact_exp(input int k);
`ifdef KEYPAD_EMU_BOUNCE_EN
        return (k >= 4) || (k % 2 == 0);
`else
        return (k >= 0);
`endif
    endfunction

    // Scanner model: rotating active-low row strobe, decodes any pulled-low column.
    function automatic logic [4:0] key_lut(input logic [3:0] r, input logic [3:0] c);
        int ri = -1;
        int ci = -1;
        for (int i = 0; i < 4; i++) begin
            if (!r[3 - i]) ri = i;
            if (!c[3 - i]) ci = i;
        end
        if (ri < 0 || ci < 0) return KEY_NONE;
        case (ri * 4 + ci)
            0: return KEY_1;   1: return KEY_2;   2: return KEY_3;     3: return KEY_A;
            4: return KEY_4;   5: return KEY_5;   6: return KEY_6;     7: return KEY_B;
            8: return KEY_7;   9: return KEY_8;   10: return KEY_9;    11: return KEY_C;
            12: return KEY_STAR; 13: return KEY_0; 14: return KEY_HASH; 15: return KEY_D;
            default: return KEY_NONE;
        endcase
    endfunction

    always @(posedge clk) if (scan_en) scan_row <= {scan_row[2:0], scan_row[3]};
    always @(negedge clk) if (scan_en && column != 4'b1111) decoded = key_lut(row, column);

    // Monitor: every done/err pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n && (done || err)) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_event: done=%0b err=%0b at cycle %0d, none expected",
                         done, err, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind{done,err}", {30'b0, done, err}, mon_e.is_err ? 32'd1 : 32'd2);
                check("event_cycle", cyc, mon_e.at);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] code, input bit expect_evt);
        evt_t e;
        start    = 1'b1;
        key_code = code;
        if (expect_evt) begin
            e.is_err = !code_ok(code);
            e.at     = e.is_err ? cyc + 1 : cyc + HOLD + GAP;
            exp_q.push_back(e);
        end
    endtask

    // Walks one full HOLD+GAP sequence starting at HOLD cycle 0.
    task automatic hold_check(input logic [3:0] expcol, input logic [3:0] altrow,
                              input logic [3:0] rowv, input int intr_k,
                              input logic [4:0] intr_code, input bit intr_exp);
        for (int k = 0; k < HOLD + GAP; k++) begin
            start = 1'b0;
            if (k == intr_k) issue(intr_code, intr_exp);
            tb_row = rowv;
            #1;
            check("column", column, (k < HOLD && contact_exp(k)) ? expcol : 4'b1111);
            tb_row = altrow;
            #1;
            check("column_other_row", column, 4'b1111);
            tb_row = rowv;
            check("busy", busy, 1);
            tick();
        end
        start = 1'b0;
    endtask

    int busy_n;
    logic [4:0] bad_codes [5];

    initial begin
        bad_codes[0] = 5'b01110; bad_codes[1] = 5'b00000; bad_codes[2] = 5'b11111;
        bad_codes[3] = 5'b10011; bad_codes[4] = 5'b10100;

        // Reset state, with the scanner lockout drive present.
        tb_row = 4'b0000;
        #12;
        check("reset_column", column, 4'b1111);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // "5" on row 1011: column 1011 for the hold, 1111 when another row strobes.
        issue(KEY_5, 1);
        tick();
        hold_check(4'b1011, 4'b0111, 4'b1011, -1, 5'b0, 0);
        check("busy_idle_5", busy, 0);

        // Scanner connected, press "D".
        decoded = KEY_NONE;
        scan_en = 1'b1;
        issue(KEY_D, 1);
        tick();
        start = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 30; i++) begin
            if (busy) busy_n++;
            tick();
        end
        scan_en = 1'b0;
        check("scanner_decoded", decoded, KEY_D);
        check("busy_length", busy_n, HOLD + GAP);

        // Invalid codes: err pulse only, nothing else moves.
        tb_row = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            issue(bad_codes[i], 1);
            tick();
            start = 1'b0;
            check("invalid_busy", busy, 0);
            check("invalid_column", column, 4'b1111);
            tick();
            check("invalid_busy_after", busy, 0);
        end

        // Start during HOLD is ignored; original timing unchanged.
        issue(KEY_5, 1);
        tick();
        hold_check(4'b1011, 4'b0111, 4'b1011, 3, KEY_1, 0);
        check("busy_idle_ignored", busy, 0);

        // Back-to-back: "1" then "3" accepted in the done cycle.
        tb_row = 4'b0111;
        issue(KEY_1, 1);
        tick();
        hold_check(4'b0111, 4'b1011, 4'b0111, HOLD + GAP - 1, KEY_3, 1);
        hold_check(4'b1101, 4'b1011, 4'b0111, -1, 5'b0, 0);
        check("busy_idle_chain", busy, 0);

        // Reset at HOLD cycle 5: column released at once, no done.
        tb_row = 4'b1011;
        issue(KEY_5, 0);
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("pre_reset_column", column, 4'b1011);
        rst_n = 1'b0;
        #1;
        check("midreset_column", column, 4'b1111);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (25) tick();
        check("post_reset_busy", busy, 0);
        tb_row = 4'b1101;
        issue(KEY_9, 1);
        tick();
        hold_check(4'b1101, 4'b1011, 4'b1101, -1, 5'b0, 0);
        check("busy_idle_9", busy, 0);

        // "*" under row lockout 0000 (bounce pattern applies when enabled).
        tb_row = 4'b0000;
        issue(KEY_STAR, 1);
        tick();
        hold_check(4'b0111, 4'b1111, 4'b0000, -1, 5'b0, 0);
        check("busy_idle_star", busy, 0);

        repeat (3) tick();
        check("pending_events", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 SHALL have parameter: HOLD_CYCLES, default 16, clock cycles the key contact stays closed per press (legal range 1..255).
REQ-002 SHALL have parameter: GAP_CYCLES, default 8, clock cycles of forced release after a press before the next press is accepted (legal range 1..255).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: start  input  1  one-cycle press request, sampled in IDLE only.
REQ-006 SHALL have port: key_code  input  5  key to press, same 5-bit code set as the keypad scanner; sampled with start.
REQ-007 SHALL have port: row  input  4  active-low row strobes from the scanner; bit 3 = top row, bit 0 = bottom row.
REQ-008 SHALL have port: column  output  4  active-low column lines to the scanner; bit 3 = left column, bit 0 = right column.
REQ-009 SHALL have port: busy  output  1  high while in HOLD or GAP.
REQ-010 SHALL have port: done  output  1  one-cycle pulse when a press sequence completes.
REQ-011 SHALL have port: err  output  1  one-cycle pulse when start carries an invalid key_code.

Function
REQ-012 SHALL use the key map: top row 1,2,3,A = 00001,00010,00011,01010; row 2: 4,5,6,B = 00100,00101,00110,01011; row 3: 7,8,9,C = 00111,01000,01001,01100; bottom row: *,0,#,D = 10000,10001,10010,01101 (left to right).
REQ-013 SHALL treat every other code as invalid; an invalid start pulses err the next cycle, leaves busy low, and stays in IDLE.
REQ-014 SHALL implement the states IDLE, HOLD and GAP.
REQ-015 SHALL, on a valid start in IDLE, latch the row/column position, enter HOLD on the next edge, and load the counter with HOLD_CYCLES-1.
REQ-016 SHALL, in HOLD, decrement the counter each cycle; at 0 it SHALL enter GAP with the counter loaded to GAP_CYCLES-1.
REQ-017 SHALL, in GAP, decrement the counter each cycle; at 0 it SHALL return to IDLE and assert done for exactly that one transition cycle.
REQ-018 SHALL close the contact for exactly HOLD_CYCLES cycles and keep it open for exactly GAP_CYCLES cycles.
REQ-019 SHALL drive column[c] = 0 combinationally, with zero cycle latency, iff the contact is closed, the latched key is in column c, and row[r] = 0 for the latched key's row r; otherwise column[c] = 1.
REQ-020 SHALL pull the latched column low whenever its row bit is low, including when row = 0000 (the scanner's lockout drive).
REQ-021 SHALL ignore start while busy; no error is flagged.
REQ-022 SHALL accept a start in the same cycle that done is asserted; the sequence restarts on the next edge.

Reset
REQ-023 SHALL, while rst_n = 0, immediately force state IDLE, counter 0, latched position cleared, busy 0, done 0, err 0, and column 1111 regardless of row.
REQ-024 SHALL, on reset asserted mid-HOLD, release column within the same cycle and produce no done pulse.

Configuration
REQ-025 SHALL support macro KEYPAD_EMU_BOUNCE_EN; when it is defined, the first min(4, HOLD_CYCLES) cycles of HOLD SHALL alternate contact closed/open, starting closed, modelling switch bounce.
REQ-026 SHALL, when KEYPAD_EMU_BOUNCE_EN is undefined, keep the contact closed for every cycle of HOLD, with no bounce logic synthesized.

Structure
REQ-027 SHALL take the 16 key-code constants, KEY_NONE = 11111, and the state encoding from a shared package keypad_pkg, which the scanner also uses.
REQ-028 SHALL instantiate one combinational sub-module, keypad_code_to_pos (key_code -> 2-bit row index, 2-bit column index, valid).

Verification
REQ-029 SHALL test: start with key_code = 00101 ("5") and row = 1011 -> column = 1011 within the same cycle for 16 cycles; row = 0111 at any time -> column = 1111.
REQ-030 SHALL test: the scanner model connected, press "D" (01101) -> scanner decoded = 01101; done pulses once after 24 cycles; busy is high for exactly 24 cycles.
REQ-031 SHALL test: start with key_code = 01110 -> err high for 1 cycle, busy stays 0, column stays 1111.
REQ-032 SHALL test: start pulsed during HOLD with key_code = 00001 -> ignored, and the original key's timing is unchanged.
REQ-033 SHALL test: rst_n pulled low at HOLD cycle 5 -> column = 1111 immediately, busy = 0, no done; a new start after release works.
REQ-034 SHALL test: with KEYPAD_EMU_BOUNCE_EN defined and row = 0000, press "*" -> column pattern 0111, 1111, 0111, 1111, then 0111 held for 12 cycles.
